gate_sweep_checker: RTL and testbench

Self-checking stimulus sequencer that sits directly upstream and downstream of a combinational gate under test (e.g. orGate). It drives every N_IN-bit input vector in ascending order, waits a settle interval, samples the gate output and compares it against a truth-table parameter. It reports pass/fail, an error count and the first failing vector. The lab uses it to replace hand-written $display truth-table benches with a synthesizable checker.

---
 rtl/gate_lab_pkg.sv | 7 +
 rtl/gate_sweep_checker.sv | 107 ++++++++++
 tb/tb_gate_sweep_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/gate_lab_pkg.sv
// gate_lab_pkg: shared sweep-checker state encoding and common 2-input truth tables
package gate_lab_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE} state_e;
   localparam logic [3:0] OR2_EXPECT  = 4'b1110;
   localparam logic [3:0] AND2_EXPECT = 4'b1000;
   localparam logic [3:0] XOR2_EXPECT = 4'b0110;
endpackage

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: walks every input vector of a combinational gate, waits a settle time,
// and compares the gate output with a truth-table parameter.
module gate_sweep_checker
   import gate_lab_pkg::*;
#(
   parameter int                  N_IN   = 2,
   parameter int                  SETTLE = 1,
   parameter logic [2**N_IN-1:0]  EXPECT = OR2_EXPECT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_y,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec
);
   localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   localparam logic [N_IN-1:0] LAST = N_IN'(2**N_IN - 1);
   localparam logic [CW-1:0] CNT_END = CW'(SETTLE - 1);
   state_e state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d, fvec_q, fvec_d;
   logic [N_IN:0] err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, fv_q, fv_d, mis;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fvec_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fvec_q  <= fvec_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fvec_d  = fvec_q;
      cnt_d   = cnt_q;
      mis     = dut_y != EXPECT[stim_q];
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_SETTLE;
            stim_d  = '0;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = '0;
            fv_d    = 1'b0;
            fvec_d  = '0;
            cnt_d   = '0;
         end
         ST_SETTLE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CNT_END ? ST_SAMPLE : ST_SETTLE;
         end
         ST_SAMPLE: begin
            err_d = err_q + (N_IN+1)'(mis);
            cnt_d = '0;
            // only the first mismatch of a sweep is latched
            if (mis && !fv_q) begin
               fv_d   = 1'b1;
               fvec_d = stim_q;
            end
            if (stim_q == LAST) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = err_q == '0 && !mis;
            end else begin
               state_d = ST_SETTLE;
               stim_d  = stim_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   assign stim       = stim_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: two checker instances (OR2 with swappable faulty gates, XOR3) compared
// every cycle against a timeline model derived from the sweep's latency and truth-table rules.
module tb_gate_sweep_checker;
   typedef struct packed {
      logic [3:0] stim;
      logic       busy, done, pass;
      logic [4:0] err;
      logic       fv;
      logic [3:0] fvec;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
   int mode = 0;
   logic [1:0] stim_a, fvec_a;
   logic [2:0] err_a, stim_b, fvec_b;
   logic [3:0] err_b;
   logic busy_a, done_a, pass_a, fv_a, y_a, busy_b, done_b, pass_b, fv_b, y_b;
   int compared = 0, mismatched = 0, cyc = 0, e0_a = 0, e0_b = 0;
   bit st_a = 0, st_b = 0;
   logic [15:0] yt_a = 16'h000E;
   always #5 clk = ~clk;
   assign y_a = mode == 1 ? 1'b0 : mode == 2 ? &stim_a : |stim_a;
   assign y_b = ^stim_b;
   gate_sweep_checker #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1110)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .dut_y(y_a), .stim(stim_a), .busy(busy_a),
      .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a));
   gate_sweep_checker #(.N_IN(3), .SETTLE(3), .EXPECT(8'b10010110)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .dut_y(y_b), .stim(stim_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b));
   function automatic logic [15:0] ytab(int m);
      return m == 1 ? 16'h0000 : m == 2 ? 16'h0008 : 16'h000E;
   endfunction
   // expected outputs t edges after the accepted start edge
   function automatic exp_t model(int n, int s, logic [15:0] ex, logic [15:0] yt, bit st, int t);
      exp_t r;
      int n2 = 1 << n;
      int l = n2 * (s + 1);
      r = '0;
      if (!st) return r;
      r.busy = t < l;
      r.done = t == l;
      r.stim = t < l ? 4'(t / (s + 1)) : 4'(n2 - 1);
      for (int k = 0; k < n2; k++)
         if ((k + 1) * (s + 1) <= t && yt[k] != ex[k]) begin
            if (!r.fv) r.fvec = 4'(k);
            r.fv = 1'b1;
            r.err = r.err + 5'd1;
         end
      r.pass = t >= l && r.err == 5'd0;
      return r;
   endfunction
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         st_a = 0;
         st_b = 0;
      end else begin
         bit bz_a, bz_b;
         bz_a = st_a && (cyc - e0_a) < 8;
         bz_b = st_b && (cyc - e0_b) < 32;
         cyc++;
         if (!bz_a && start_a) begin
            st_a = 1;
            e0_a = cyc;
            yt_a = ytab(mode);
         end
         if (!bz_b && start_b) begin
            st_b = 1;
            e0_b = cyc;
         end
      end
   end
   task automatic cmp(string nm, exp_t a, exp_t e);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("FAIL %s @%0d: got %h expected %h", nm, cyc, a, e);
      end
   endtask
   task automatic chk(string nm, int a, int e);
      compared++;
      if (a != e) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask
   always @(posedge clk) begin
      exp_t act;
      #1;
      act = {2'b0, stim_a, busy_a, done_a, pass_a, 2'b0, err_a, fv_a, 2'b0, fvec_a};
      cmp("sweep_a", act, model(2, 1, 16'h000E, yt_a, st_a, cyc - e0_a));
      act = {1'b0, stim_b, busy_b, done_b, pass_b, 1'b0, err_b, fv_b, 1'b0, fvec_b};
      cmp("sweep_b", act, model(3, 3, 16'h0096, 16'h0096, st_b, cyc - e0_b));
   end
   task automatic wait_done_a(int e, string nm);
      for (int i = 0; i < 40 && !done_a; i++) @(negedge clk);
      chk(nm, cyc - e, 8);
   endtask
   task automatic run_a(int m, int e_err, int e_vec, int e_pass);
      int e;
      mode = m;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      e = cyc;
      wait_done_a(e, "done_lat_a");
      chk("err_a", int'(err_a), e_err);
      chk("fv_a", int'(fv_a), e_err > 0 ? 1 : 0);
      chk("fvec_a", int'(fvec_a), e_vec);
      chk("pass_a", int'(pass_a), e_pass);
      repeat (3) @(negedge clk);
   endtask
   initial begin
      int e, e2, seen;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_err", int'(err_a), 0);
      repeat (2) @(negedge clk);
      run_a(0, 0, 0, 1);
      run_a(1, 3, 1, 0);
      run_a(2, 2, 1, 0);
      mode = 0;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      e = cyc;
      repeat (4) @(negedge clk);
      chk("mid_busy", int'(busy_a), 1);
      rst = 1'b1;
      #1;
      chk("async_rst", int'({stim_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a}), 0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_a) seen = 1;
      end
      chk("no_done_after_rst", seen, 0);
      run_a(0, 0, 0, 1);
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) e = cyc;
      wait_done_a(e, "held_done_lat");
      @(negedge clk) e2 = cyc;
      start_a = 1'b0;
      chk("restart_edge", e2 - e, 9);
      chk("restart_busy", int'(busy_a), 1);
      wait_done_a(e2, "restart_done_lat");
      chk("restart_pass", int'(pass_a), 1);
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      e = cyc;
      for (int i = 0; i < 100 && !done_b; i++) @(negedge clk);
      chk("done_lat_b", cyc - e, 32);
      chk("pass_b", int'(pass_b), 1);
      chk("err_b", int'(err_b), 0);
      chk("stim_b_last", int'(stim_b), 7);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
